row_window_buffer_fp16: RTL and testbench

// Turns a raster stream of fp16 pixels (one per accepted beat) into 1 x WINDOW_WIDTH horizontal windows.

---
 rtl/row_window_buffer_fp16.sv | 218 +++++++++++++++++++++
 tb/tb_row_window_buffer_fp16.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/row_window_buffer_fp16.sv
// row_window_buffer_fp16
// Turns a raster stream of fp16 pixels into 1 x WINDOW_WIDTH horizontal
// windows. Each window is centred on one pixel, and its column/row tags
// belong to that centre pixel. Taps that fall left of column 0 or right of
// column IMAGE_WIDTH-1 are padded with zero (BORDER_MODE 0) or with the
// nearest edge pixel (BORDER_MODE 1). At the end of each row the block
// stalls for HALF cycles while it emits the trailing windows.
//
// Ports
//   clk_i     clock; everything updates on the rising edge
//   rst_i     synchronous active-high reset
//   pixel_i   input pixel (raw fp bits, passed through bit-exact)
//   col_i     column of pixel_i
//   row_i     row of pixel_i
//   valid_i   pixel_i/col_i/row_i valid
//   ready_o   block can accept; a beat is accepted on valid_i && ready_o
//   window_o  window_o[0][k] holds column col_o-HALF+k
//   col_o     centre column of window_o
//   row_o     row of window_o
//   valid_o   single-cycle pulse per emitted window
module row_window_buffer_fp16 #(
    parameter int EXP_WIDTH     = 5,
    parameter int FRAC_WIDTH    = 10,
    parameter int WINDOW_WIDTH  = 3,
    parameter int IMAGE_WIDTH   = 640,
    parameter int BORDER_MODE   = 0,
    localparam int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH
) (
    input  logic                                               clk_i,
    input  logic                                               rst_i,
    input  logic [FP_WIDTH_REG-1:0]                            pixel_i,
    input  logic [15:0]                                        col_i,
    input  logic [15:0]                                        row_i,
    input  logic                                               valid_i,
    output logic                                               ready_o,
    output logic [0:0][WINDOW_WIDTH-1:0][FP_WIDTH_REG-1:0]     window_o,
    output logic [15:0]                                        col_o,
    output logic [15:0]                                        row_o,
    output logic                                               valid_o
);

    localparam int HALF = (WINDOW_WIDTH - 1) / 2;
    localparam int CW   = $clog2(WINDOW_WIDTH + 1);

    typedef enum logic [1:0] {
        FILL,
        STREAM,
        FLUSH
    } state_t;

    state_t                                            state_q, state_d;
    logic [CW-1:0]                                     fillCount_q, fillCount_d;
    logic [CW-1:0]                                     flushCount_q, flushCount_d;
    logic [WINDOW_WIDTH-1:0][FP_WIDTH_REG-1:0]         sr_q, sr_d;
    logic [15:0]                                       rowLatch_q, rowLatch_d;
    logic [FP_WIDTH_REG-1:0]                           leftEdge_q, leftEdge_d;
    logic [FP_WIDTH_REG-1:0]                           rightEdge_q, rightEdge_d;
    logic [0:0][WINDOW_WIDTH-1:0][FP_WIDTH_REG-1:0]    window_q, window_d;
    logic [15:0]                                       colOut_q, colOut_d;
    logic [15:0]                                       rowOut_q, rowOut_d;
    logic                                              validOut_q, validOut_d;

    logic                                              accept;
    logic [FP_WIDTH_REG-1:0]                           padLeft;
    logic [FP_WIDTH_REG-1:0]                           padRight;

    // The only time we refuse input is while the trailing windows of a row
    // are being pushed out; everything else accepts a beat every cycle.
    assign ready_o = (state_q != FLUSH);
    assign accept  = valid_i && ready_o;

    // Out-of-image taps either read as all-zero or repeat the pixel that was
    // latched when the first / last column of the row was accepted.
    assign padLeft  = (BORDER_MODE == 1) ? leftEdge_q  : '0;
    assign padRight = (BORDER_MODE == 1) ? rightEdge_q : '0;

    // Next-state logic. Each accepted beat (or each FLUSH cycle) shifts one
    // value into the top of the shift register. When a window is due, the
    // shifted register already holds columns centre-HALF..centre+HALF, so the
    // window is just the shifted register with border taps substituted. The
    // centre column is kept in col_o itself, which doubles as the column
    // counter: 0 on the first window of a row, +1 for every later one.
    always_comb begin : nextStateLogic
        int                      tapCol;
        logic                    emit;
        logic                    doShift;
        logic [FP_WIDTH_REG-1:0] shiftIn;
        logic [15:0]             centre;

        tapCol       = 0;
        emit         = 1'b0;
        doShift      = 1'b0;
        shiftIn      = '0;
        centre       = colOut_q;
        state_d      = state_q;
        fillCount_d  = fillCount_q;
        flushCount_d = flushCount_q;
        sr_d         = sr_q;
        rowLatch_d   = rowLatch_q;
        leftEdge_d   = leftEdge_q;
        rightEdge_d  = rightEdge_q;
        window_d     = window_q;
        colOut_d     = colOut_q;
        rowOut_d     = rowOut_q;
        validOut_d   = 1'b0;

        case (state_q)
            FILL: begin
                if (accept) begin
                    doShift = 1'b1;
                    shiftIn = pixel_i;
                    if (col_i == 16'd0) begin
                        fillCount_d = CW'(1);
                        rowLatch_d  = row_i;
                        leftEdge_d  = pixel_i;
                    end else if (fillCount_q == CW'(HALF)) begin
                        emit    = 1'b1;
                        centre  = 16'd0;
                        state_d = STREAM;
                    end else begin
                        fillCount_d = fillCount_q + CW'(1);
                    end
                end
            end
            STREAM: begin
                if (accept) begin
                    doShift = 1'b1;
                    shiftIn = pixel_i;
                    if (col_i == 16'd0) begin
                        state_d     = FILL;
                        fillCount_d = CW'(1);
                        rowLatch_d  = row_i;
                        leftEdge_d  = pixel_i;
                    end else begin
                        emit   = 1'b1;
                        centre = colOut_q + 16'd1;
                        if (col_i == 16'(IMAGE_WIDTH - 1)) begin
                            rightEdge_d  = pixel_i;
                            state_d      = FLUSH;
                            flushCount_d = '0;
                        end
                    end
                end
            end
            FLUSH: begin
                doShift = 1'b1;
                shiftIn = padRight;
                emit    = 1'b1;
                centre  = colOut_q + 16'd1;
                if (flushCount_q == CW'(HALF - 1)) begin
                    state_d     = FILL;
                    fillCount_d = '0;
                end else begin
                    flushCount_d = flushCount_q + CW'(1);
                end
            end
            default: begin
                state_d     = FILL;
                fillCount_d = '0;
            end
        endcase

        if (doShift) begin
            sr_d = {shiftIn, sr_q[WINDOW_WIDTH-1:1]};
        end

        if (emit) begin
            for (int k = 0; k < WINDOW_WIDTH; k++) begin
                tapCol = int'(centre) - HALF + k;
                if (tapCol < 0) begin
                    window_d[0][k] = padLeft;
                end else if (tapCol >= IMAGE_WIDTH) begin
                    window_d[0][k] = padRight;
                end else begin
                    window_d[0][k] = sr_d[k];
                end
            end
            colOut_d   = centre;
            rowOut_d   = rowLatch_q;
            validOut_d = 1'b1;
        end
    end

    // State and output registers; reset drops any partial row silently.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= FILL;
            fillCount_q  <= '0;
            flushCount_q <= '0;
            sr_q         <= '0;
            rowLatch_q   <= '0;
            leftEdge_q   <= '0;
            rightEdge_q  <= '0;
            window_q     <= '0;
            colOut_q     <= '0;
            rowOut_q     <= '0;
            validOut_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            fillCount_q  <= fillCount_d;
            flushCount_q <= flushCount_d;
            sr_q         <= sr_d;
            rowLatch_q   <= rowLatch_d;
            leftEdge_q   <= leftEdge_d;
            rightEdge_q  <= rightEdge_d;
            window_q     <= window_d;
            colOut_q     <= colOut_d;
            rowOut_q     <= rowOut_d;
            validOut_q   <= validOut_d;
        end
    end

    assign window_o = window_q;
    assign col_o    = colOut_q;
    assign row_o    = rowOut_q;
    assign valid_o  = validOut_q;

endmodule

// File: tb/tb_row_window_buffer_fp16.sv
// tb_row_window_buffer_fp16
// Drives one pixel stream into two copies of row_window_buffer_fp16
// (zero padding and edge replication, 3 taps, 4-pixel rows) and checks
// every emitted window against constant tables and a row-array model.
module tb_row_window_buffer_fp16;

    localparam int IW   = 4;
    localparam int HALF = 1;

    typedef logic [0:0][2:0][15:0] winBus_t;

    typedef struct {
        int          mode;
        logic [15:0] t0;
        logic [15:0] t1;
        logic [15:0] t2;
        logic [15:0] col;
        logic [15:0] row;
    } win_t;

    typedef struct {
        logic [15:0] pix;
        logic [15:0] a0, a1, a2;
        logic [15:0] b0, b1, b2;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [15:0] pixelIn;
    logic [15:0] colIn;
    logic [15:0] rowIn;
    logic        validIn;

    logic        dut0Ready, dut1Ready;
    winBus_t     dut0Window, dut1Window;
    logic [15:0] dut0Col, dut1Col;
    logic [15:0] dut0Row, dut1Row;
    logic        dut0Valid, dut1Valid;

    int          checks;
    int          failures;
    bit          modelOn;
    win_t        obsQ[$];
    win_t        expQ[$];
    vec_t        vecs[4];
    logic [15:0] rowPix[IW];
    logic [15:0] modelRow;

    row_window_buffer_fp16 #(
        .EXP_WIDTH(5), .FRAC_WIDTH(10), .WINDOW_WIDTH(3),
        .IMAGE_WIDTH(IW), .BORDER_MODE(0)
    ) dutZero (
        .clk_i(clk), .rst_i(rst), .pixel_i(pixelIn), .col_i(colIn),
        .row_i(rowIn), .valid_i(validIn), .ready_o(dut0Ready),
        .window_o(dut0Window), .col_o(dut0Col), .row_o(dut0Row),
        .valid_o(dut0Valid)
    );

    row_window_buffer_fp16 #(
        .EXP_WIDTH(5), .FRAC_WIDTH(10), .WINDOW_WIDTH(3),
        .IMAGE_WIDTH(IW), .BORDER_MODE(1)
    ) dutEdge (
        .clk_i(clk), .rst_i(rst), .pixel_i(pixelIn), .col_i(colIn),
        .row_i(rowIn), .valid_i(validIn), .ready_o(dut1Ready),
        .window_o(dut1Window), .col_o(dut1Col), .row_o(dut1Row),
        .valid_o(dut1Valid)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something never returns.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic win_t mkWin(input int mode, input winBus_t w,
                                   input logic [15:0] c, input logic [15:0] r);
        win_t x;
        x.mode = mode;
        x.t0   = w[0][0];
        x.t1   = w[0][1];
        x.t2   = w[0][2];
        x.col  = c;
        x.row  = r;
        return x;
    endfunction

    // Capture every emitted window, sampled on the falling edge.
    always @(negedge clk) begin
        if (dut0Valid) obsQ.push_back(mkWin(0, dut0Window, dut0Col, dut0Row));
        if (dut1Valid) obsQ.push_back(mkWin(1, dut1Window, dut1Col, dut1Row));
    end

    // Reference: a tap is the row pixel at its column, or the border value.
    function automatic logic [15:0] tapVal(input int mode, input int c);
        if (c < 0)   return (mode == 1) ? rowPix[0] : 16'h0000;
        if (c >= IW) return (mode == 1) ? rowPix[IW-1] : 16'h0000;
        return rowPix[c];
    endfunction

    task automatic pushExpect(input int centre);
        win_t w;
        for (int m = 0; m < 2; m++) begin
            w.mode = m;
            w.t0   = tapVal(m, centre - 1);
            w.t1   = tapVal(m, centre);
            w.t2   = tapVal(m, centre + 1);
            w.col  = 16'(centre);
            w.row  = modelRow;
            expQ.push_back(w);
        end
    endtask

    // A window is due once its right-most tap has arrived; the last column
    // of a row also releases the windows whose right taps are off-image.
    task automatic modelAccept(input logic [15:0] pix, input int c,
                               input logic [15:0] r);
        if (c == 0) modelRow = r;
        rowPix[c] = pix;
        if (c >= HALF) pushExpect(c - HALF);
        if (c == IW - 1) begin
            for (int cc = IW - HALF; cc < IW; cc++) pushExpect(cc);
        end
    endtask

    task automatic checkVal(input string name, input logic [63:0] got,
                            input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // Present one beat after gap idle cycles and hold it until accepted;
    // stall returns how many cycles ready_o kept it waiting.
    task automatic applyStimulus(input logic [15:0] pix, input int c,
                                 input logic [15:0] r, input int gap,
                                 output int stall);
        repeat (gap) begin
            @(negedge clk);
            validIn = 1'b0;
        end
        @(negedge clk);
        pixelIn = pix;
        colIn   = 16'(c);
        rowIn   = r;
        validIn = 1'b1;
        stall   = 0;
        while (!(dut0Ready && dut1Ready) && stall < 20) begin
            @(negedge clk);
            stall++;
        end
        if (stall >= 20) begin
            checks++;
            failures++;
            $display("[TB] FAIL acceptTimeout col=%0d: got ready low 20 cycles, want accept", c);
        end
        @(posedge clk);
        if (modelOn) modelAccept(pix, c, r);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            validIn = 1'b0;
        end
    endtask

    task automatic runTableRow(input logic [15:0] rowVal, input int gapMid,
                               output int firstStall);
        int st;
        firstStall = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i].pix, i, (i == 0) ? rowVal : 16'hFFFF,
                          (i == 2) ? gapMid : 0, st);
            if (i == 0) firstStall = st;
        end
    endtask

    task automatic loadTableExpect(input logic [15:0] rowVal);
        win_t w;
        for (int i = 0; i < 4; i++) begin
            w.mode = 0; w.col = 16'(i); w.row = rowVal;
            w.t0 = vecs[i].a0; w.t1 = vecs[i].a1; w.t2 = vecs[i].a2;
            expQ.push_back(w);
            w.mode = 1;
            w.t0 = vecs[i].b0; w.t1 = vecs[i].b1; w.t2 = vecs[i].b2;
            expQ.push_back(w);
        end
    endtask

    // Compare captured windows with expected ones in order, then clear both.
    task automatic checkOutput(input string name);
        int n;
        checks++;
        if (obsQ.size() != expQ.size()) begin
            failures++;
            $display("[TB] FAIL %s.count: got %0d windows, want %0d",
                     name, obsQ.size(), expQ.size());
        end
        n = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (obsQ[i].mode !== expQ[i].mode || obsQ[i].t0 !== expQ[i].t0 ||
                obsQ[i].t1 !== expQ[i].t1 || obsQ[i].t2 !== expQ[i].t2 ||
                obsQ[i].col !== expQ[i].col || obsQ[i].row !== expQ[i].row) begin
                failures++;
                $display("[TB] FAIL %s[%0d]: got mode=%0d col=%0d row=%h taps=%h/%h/%h, want mode=%0d col=%0d row=%h taps=%h/%h/%h",
                         name, i, obsQ[i].mode, obsQ[i].col, obsQ[i].row,
                         obsQ[i].t0, obsQ[i].t1, obsQ[i].t2,
                         expQ[i].mode, expQ[i].col, expQ[i].row,
                         expQ[i].t0, expQ[i].t1, expQ[i].t2);
            end
        end
        obsQ.delete();
        expQ.delete();
    endtask

    task automatic checkResetState(input string name);
        checkVal({name, ".window0"}, 64'(dut0Window), 64'h0);
        checkVal({name, ".col0"},    64'(dut0Col),    64'h0);
        checkVal({name, ".row0"},    64'(dut0Row),    64'h0);
        checkVal({name, ".valid0"},  64'(dut0Valid),  64'h0);
        checkVal({name, ".ready0"},  64'(dut0Ready),  64'h1);
        checkVal({name, ".window1"}, 64'(dut1Window), 64'h0);
        checkVal({name, ".valid1"},  64'(dut1Valid),  64'h0);
        checkVal({name, ".ready1"},  64'(dut1Ready),  64'h1);
    endtask

    initial begin
        int st;
        int lastCol;
        int len;
        int gap;
        logic [15:0] rowv;

        vecs[0] = '{16'h3C00, 16'h0000, 16'h3C00, 16'h4000, 16'h3C00, 16'h3C00, 16'h4000};
        vecs[1] = '{16'h4000, 16'h3C00, 16'h4000, 16'h4200, 16'h3C00, 16'h4000, 16'h4200};
        vecs[2] = '{16'h4200, 16'h4000, 16'h4200, 16'h4400, 16'h4000, 16'h4200, 16'h4400};
        vecs[3] = '{16'h4400, 16'h4200, 16'h4400, 16'h0000, 16'h4200, 16'h4400, 16'h4400};

        checks   = 0;
        failures = 0;
        modelOn  = 1'b0;
        modelRow = '0;
        for (int i = 0; i < IW; i++) rowPix[i] = '0;
        rst     = 1'b1;
        validIn = 1'b0;
        pixelIn = '0;
        colIn   = '0;
        rowIn   = '0;

        repeat (3) @(negedge clk);
        checkResetState("reset");
        rst = 1'b0;

        $display("[TB] basic row, both border modes");
        runTableRow(16'd5, 0, st);
        @(negedge clk);
        validIn = 1'b0;
        checkVal("flushReadyLow.0", 64'(dut0Ready), 64'h0);
        checkVal("flushReadyLow.1", 64'(dut1Ready), 64'h0);
        @(negedge clk);
        checkVal("flushReadyBack.0", 64'(dut0Ready), 64'h1);
        checkVal("flushReadyBack.1", 64'(dut1Ready), 64'h1);
        idle(3);
        loadTableExpect(16'd5);
        checkOutput("basicRow");

        $display("[TB] idle gap mid-row");
        runTableRow(16'd5, 3, st);
        idle(4);
        loadTableExpect(16'd5);
        checkOutput("gapRow");

        $display("[TB] back-to-back rows across flush");
        runTableRow(16'd5, 0, st);
        runTableRow(16'd6, 0, st);
        checkVal("flushStall", 64'(st), 64'(HALF));
        idle(4);
        loadTableExpect(16'd5);
        loadTableExpect(16'd6);
        checkOutput("backToBack");

        $display("[TB] reset mid-row");
        modelOn = 1'b1;
        applyStimulus(16'h1234, 0, 16'd9, 0, st);
        applyStimulus(16'h5678, 1, 16'd9, 0, st);
        modelOn = 1'b0;
        @(negedge clk);
        validIn = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        checkResetState("midRowReset");
        rst = 1'b0;
        runTableRow(16'd5, 0, st);
        idle(4);
        loadTableExpect(16'd5);
        checkOutput("afterReset");

        $display("[TB] row restart");
        modelOn = 1'b1;
        applyStimulus(16'hABCD, 0, 16'd11, 0, st);
        applyStimulus(16'h0123, 1, 16'd11, 0, st);
        modelOn = 1'b0;
        runTableRow(16'd7, 0, st);
        checkVal("restartStall", 64'(st), 64'h0);
        idle(4);
        loadTableExpect(16'd7);
        checkOutput("restartRow");

        $display("[TB] random rows");
        modelOn = 1'b1;
        lastCol = -1;
        for (int r = 0; r < 25; r++) begin
            len  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, IW - 1) : IW;
            rowv = 16'($urandom);
            for (int c = 0; c < len; c++) begin
                gap = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2) : 0;
                applyStimulus(16'($urandom), c,
                              (c == 0) ? rowv : 16'($urandom), gap, st);
                checkVal($sformatf("randStall r%0d c%0d", r, c), 64'(st),
                         64'((lastCol == IW - 1 && gap == 0) ? HALF : 0));
                lastCol = c;
            end
        end
        idle(5);
        modelOn = 1'b0;
        checkOutput("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
